// File: rtl/hps_io_sequencer.sv
// Splits the HPS SPI word stream into command/data words per enable window and locks one channel.
// Optional idle watchdog enabled by defining HPS_SEQ_WATCHDOG_EN.
module hps_io_sequencer #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [31:0]      gp_out,
  input  logic             io_strobe,
  input  logic [15:0]      resp_fpga,
  input  logic [15:0]      resp_osd,
  input  logic [15:0]      resp_io,
  output logic [15:0]      gp_in,
  output logic [1:0]       ch_sel,
  output logic [15:0]      cmd,
  output logic             cmd_valid,
  output logic [15:0]      data,
  output logic             data_valid,
  output logic [CNT_W-1:0] word_cnt,
  output logic             xfer_end,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_sel_q, ch_sel_d;
  logic [15:0]      cmd_q, cmd_d, data_q, data_d, gp_in_q, gp_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             ovf_q, ovf_d;
  logic             cmd_valid_q, cmd_valid_d, data_valid_q, data_valid_d;
  logic             xfer_end_q, xfer_end_d;

  logic [15:0] word;
  logic [2:0]  en;         // {io, osd, fpga}
  logic [2:0]  lock_mask;
  logic [2:0]  avail;
  logic        locked_en;
  logic        timeout_hit;
  logic        unused_gp_bits;

  assign word           = gp_out[15:0];
  assign en             = gp_out[20:18];
  assign unused_gp_bits = ^{gp_out[31:21], gp_out[17:16]};

  always_comb begin
    case (ch_sel_q)
      2'd1:    lock_mask = 3'b001;
      2'd2:    lock_mask = 3'b010;
      2'd3:    lock_mask = 3'b100;
      default: lock_mask = 3'b000;
    endcase
  end
  assign locked_en = |(en & lock_mask);

`ifdef HPS_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic [2:0]      blk_q, blk_d;   // channels that timed out and still hold their enable
  assign avail = en & ~blk_q;
`else
  assign avail = en;
`endif

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ch_sel_d     = ch_sel_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    ovf_d        = ovf_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    xfer_end_d   = 1'b0;
    timeout_hit  = 1'b0;
    gp_in_d      = '0;
`ifdef HPS_SEQ_WATCHDOG_EN
    wd_d  = '0;
    blk_d = blk_q & en;
`endif

    case (state_q)
      S_IDLE: begin
        if      (avail[2]) ch_sel_d = 2'd3;
        else if (avail[1]) ch_sel_d = 2'd2;
        else if (avail[0]) ch_sel_d = 2'd1;
        if (|avail) state_d = S_CMD;
      end
      S_CMD: begin
        if (io_strobe) begin
          cmd_d       = word;
          cmd_valid_d = 1'b1;
          cnt_d       = '0;
          first_d     = 1'b1;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (io_strobe) begin
          data_d       = word;
          data_valid_d = 1'b1;
          // The first data word keeps index 0; later words advance and stick at all-ones.
          if (first_q)     first_d = 1'b0;
          else if (&cnt_q) ovf_d   = 1'b1;
          else             cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef HPS_SEQ_WATCHDOG_EN
    if (state_q != S_IDLE) begin
      if (io_strobe)                            wd_d        = '0;
      else if (wd_q == WD_W'(TIMEOUT - 1))      timeout_hit = 1'b1;
      else                                      wd_d        = wd_q + 1'b1;
    end
    if (timeout_hit && locked_en) blk_d = blk_d | lock_mask;
`endif

    if (state_q != S_IDLE && (!locked_en || timeout_hit)) begin
      xfer_end_d = 1'b1;
      ch_sel_d   = 2'd0;
      state_d    = S_IDLE;
    end

    // Mux on the next channel so gp_in is 0 exactly while ch_sel reads 0.
    case (ch_sel_d)
      2'd1:    gp_in_d = resp_fpga;
      2'd2:    gp_in_d = resp_osd;
      2'd3:    gp_in_d = resp_io;
      default: gp_in_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same snapshot.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_sel_q     <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      gp_in_q      <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      ovf_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      xfer_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_sel_q     <= ch_sel_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      gp_in_q      <= gp_in_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      ovf_q        <= ovf_d;
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      xfer_end_q   <= xfer_end_d;
    end
  end

`ifdef HPS_SEQ_WATCHDOG_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      blk_q <= '0;
    end else begin
      wd_q  <= wd_d;
      blk_q <= blk_d;
    end
  end
`endif

  assign gp_in      = gp_in_q;
  assign ch_sel     = ch_sel_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign word_cnt   = cnt_q;
  assign xfer_end   = xfer_end_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_hps_io_sequencer.sv
// Directed bench for hps_io_sequencer with a transaction-level reference model checked every cycle.
module tb_hps_io_sequencer;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 16;
`ifdef HPS_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic [31:0]      gp_out  = '0;
  logic             io_strobe = 1'b0;
  logic [15:0]      resp_fpga = '0, resp_osd = '0, resp_io = '0;
  logic [15:0]      gp_in, cmd, data;
  logic [1:0]       ch_sel;
  logic             cmd_valid, data_valid, xfer_end, overflow;
  logic [CNT_W-1:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hps_io_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset), .gp_out(gp_out), .io_strobe(io_strobe),
    .resp_fpga(resp_fpga), .resp_osd(resp_osd), .resp_io(resp_io),
    .gp_in(gp_in), .ch_sel(ch_sel), .cmd(cmd), .cmd_valid(cmd_valid),
    .data(data), .data_valid(data_valid), .word_cnt(word_cnt),
    .xfer_end(xfer_end), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the transaction (locked channel, whether the command arrived,
  // how many data words so far) and derives the outputs from those counts.
  int          m_ch, m_n, m_idle;
  bit          m_got;
  bit [2:0]    m_blk;
  logic [15:0] e_cmd, e_data, e_gp;
  int          e_cnt;
  bit          e_cv, e_dv, e_xe, e_ovf;

  task automatic model_reset();
    m_ch = 0; m_n = 0; m_idle = 0; m_got = 0; m_blk = '0;
    e_cmd = '0; e_data = '0; e_gp = '0; e_cnt = 0;
    e_cv = 0; e_dv = 0; e_xe = 0; e_ovf = 0;
  endtask

  task automatic model_step();
    logic [2:0] en, avail;
    en = gp_out[20:18];
    e_cv = 0; e_dv = 0; e_xe = 0;
    if (m_ch == 0) begin
      avail = en & ~m_blk;
      if      (avail[2]) m_ch = 3;
      else if (avail[1]) m_ch = 2;
      else if (avail[0]) m_ch = 1;
      m_got = 0; m_idle = 0;
    end else begin
      if (io_strobe) begin
        m_idle = 0;
        if (!m_got) begin
          m_got = 1; m_n = 0; e_cmd = gp_out[15:0]; e_cv = 1; e_cnt = 0;
        end else begin
          m_n++;
          e_data = gp_out[15:0]; e_dv = 1;
          e_cnt = (m_n - 1 > 3) ? 3 : m_n - 1;
          if (m_n > 4) e_ovf = 1;
        end
      end else begin
        m_idle++;
      end
      if (!en[m_ch-1]) begin
        e_xe = 1; m_ch = 0;
      end else if (WD && m_idle == TIMEOUT) begin
        e_xe = 1; m_blk[m_ch-1] = 1'b1; m_ch = 0;
      end
    end
    m_blk = m_blk & en;
    case (m_ch)
      1:       e_gp = resp_fpga;
      2:       e_gp = resp_osd;
      3:       e_gp = resp_io;
      default: e_gp = '0;
    endcase
  endtask

  initial begin : compare
    forever begin
      @(posedge clk_sys);
      if (reset) model_reset();
      else       model_step();
      #1;
      check("ch_sel",     32'(ch_sel),     32'(m_ch));
      check("cmd",        32'(cmd),        32'(e_cmd));
      check("cmd_valid",  32'(cmd_valid),  32'(e_cv));
      check("data",       32'(data),       32'(e_data));
      check("data_valid", 32'(data_valid), 32'(e_dv));
      check("word_cnt",   32'(word_cnt),   32'(e_cnt));
      check("xfer_end",   32'(xfer_end),   32'(e_xe));
      check("overflow",   32'(overflow),   32'(e_ovf));
      check("gp_in",      32'(gp_in),      32'(e_gp));
    end
  end

  // en = {io, osd, fpga}; inputs change on the falling edge, results are visible one edge later.
  task automatic step(input logic [2:0] en, input logic stb, input logic [15:0] w);
    gp_out    = {11'b0, en, 2'b00, w};
    io_strobe = stb;
    @(negedge clk_sys);
  endtask

  logic [1:0] exp_cnt6 [6];

  initial begin : stimulus
    exp_cnt6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    repeat (2) @(negedge clk_sys);
    check("rst_ch_sel", 32'(ch_sel), 0);
    check("rst_gp_in",  32'(gp_in), 0);
    check("rst_ovf",    32'(overflow), 0);
    reset = 1'b0;
    step(3'b000, 1'b0, 16'h0);

    // IO transaction: command plus two data words
    resp_io = 16'h0C0C;
    step(3'b100, 1'b0, 16'h0);     check("s1_lock", 32'(ch_sel), 3);
    step(3'b100, 1'b1, 16'h0021);  check("s1_cv", 32'(cmd_valid), 1); check("s1_cmd", 32'(cmd), 32'h21);
    step(3'b100, 1'b1, 16'hAAAA);  check("s1_dv0", 32'(data_valid), 1); check("s1_cnt0", 32'(word_cnt), 0);
    step(3'b100, 1'b1, 16'h5555);  check("s1_data1", 32'(data), 32'h5555); check("s1_cnt1", 32'(word_cnt), 1);
    step(3'b000, 1'b0, 16'h0);     check("s1_xe", 32'(xfer_end), 1); check("s1_ch0", 32'(ch_sel), 0);
    step(3'b000, 1'b0, 16'h0);     check("s1_xe_pulse", 32'(xfer_end), 0);

    // FPGA and OSD together: OSD wins, no preemption, relock to FPGA afterwards
    resp_osd = 16'h1234; resp_fpga = 16'hBEEF;
    step(3'b011, 1'b0, 16'h0);     check("s2_lock", 32'(ch_sel), 2); check("s2_gp", 32'(gp_in), 32'h1234);
    step(3'b010, 1'b0, 16'h0);     check("s2_nopre", 32'(ch_sel), 2); check("s2_noxe", 32'(xfer_end), 0);
    resp_osd = 16'h4321;
    step(3'b011, 1'b0, 16'h0);     check("s2_gp2", 32'(gp_in), 32'h4321); check("s2_hold", 32'(ch_sel), 2);
    step(3'b001, 1'b0, 16'h0);     check("s2_xe", 32'(xfer_end), 1); check("s2_gp0", 32'(gp_in), 0);
    step(3'b001, 1'b0, 16'h0);     check("s2_relock", 32'(ch_sel), 1); check("s2_gpf", 32'(gp_in), 32'hBEEF);
    step(3'b000, 1'b0, 16'h0);
    step(3'b000, 1'b1, 16'h9999);  check("idle_strobe", 32'(cmd_valid), 0);

    // Saturating word counter and sticky overflow, back-to-back strobes
    step(3'b100, 1'b0, 16'h0);
    step(3'b100, 1'b1, 16'h00C3);
    for (int i = 0; i < 6; i++) begin
      step(3'b100, 1'b1, 16'h0100 + 16'(i));
      check("s3_cnt", 32'(word_cnt), 32'(exp_cnt6[i]));
      check("s3_ovf", 32'(overflow), (i >= 4) ? 1 : 0);
    end
    step(3'b100, 1'b0, 16'h0);     check("s3_ovf_hold", 32'(overflow), 1);

    // Strobe coincident with the enable drop
    step(3'b000, 1'b1, 16'h7777);
    check("s4_dv", 32'(data_valid), 1); check("s4_xe", 32'(xfer_end), 1); check("s4_data", 32'(data), 32'h7777);
    step(3'b000, 1'b0, 16'h0);     check("s4_sticky", 32'(overflow), 1);

    // Reset mid-transaction
    step(3'b100, 1'b0, 16'h0);
    step(3'b100, 1'b1, 16'h00D1);
    #2 reset = 1'b1; gp_out = '0; io_strobe = 1'b0;
    #1 check("rst_mid_ch", 32'(ch_sel), 0); check("rst_mid_ovf", 32'(overflow), 0);
    @(negedge clk_sys); reset = 1'b0;

    // Watchdog expiry (or, without it, a long idle window that must stay open)
    step(3'b100, 1'b0, 16'h0);     check("wd_lock", 32'(ch_sel), 3);
    step(3'b100, 1'b1, 16'h00E0);
    if (WD) begin
      for (int i = 1; i <= TIMEOUT; i++) begin
        step(3'b100, 1'b0, 16'h0);
        check("wd_xe", 32'(xfer_end), (i == TIMEOUT) ? 1 : 0);
      end
      check("wd_ch0", 32'(ch_sel), 0);
      repeat (3) begin step(3'b100, 1'b0, 16'h0); check("wd_nolock", 32'(ch_sel), 0); end
      step(3'b000, 1'b0, 16'h0);
      step(3'b100, 1'b0, 16'h0);   check("wd_relock", 32'(ch_sel), 3);
    end else begin
      for (int i = 0; i < TIMEOUT + 4; i++) step(3'b100, 1'b0, 16'h0);
      check("nowd_open", 32'(ch_sel), 3); check("nowd_noxe", 32'(xfer_end), 0);
    end
    step(3'b000, 1'b0, 16'h0);
    step(3'b000, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : time_guard
    #200000;
    $display("FAIL time_guard: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hps_io_sequencer.md
# hps_io_sequencer

Transaction sequencer between the HPS SPI word interface and the core's command consumers. Splits the received word stream into one command word plus data words per enable window. Arbitrates between the three HPS channels (FPGA, OSD, IO) and locks one per transaction. Returns the locked channel's response word to the SPI slave.

## Interface
- `CNT_W`, 12: width of the data-word counter.
- `TIMEOUT`, 65535: idle-cycle limit for the watchdog. Used only when `HPS_SEQ_WATCHDOG_EN` is defined.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `gp_out`  in  32  word bus from the interface block:
  - [15:0] received word.
  - [18] fpga_en, [19] osd_en, [20] io_en.
  - All other bits ignored.
- `io_strobe`  in  1  one-cycle pulse; `gp_out[15:0]` holds a new word.
- `resp_fpga`, `resp_osd`, `resp_io`  in  16 each  per-channel response words.
- `gp_in`  out  16  response word to the SPI slave.
- `ch_sel`  out  2  locked channel: 0 none, 1 FPGA, 2 OSD, 3 IO.
- `cmd`  out  16  command word latched for the current transaction.
- `cmd_valid`  out  1  pulse when the command word is captured.
- `data`  out  16  current data word.
- `data_valid`  out  1  pulse per data word.
- `word_cnt`  out  CNT_W  index of the word on `data`; the first data word is 0.
- `xfer_end`  out  1  pulse when the transaction closes.
- `overflow`  out  1  sticky flag: a data word arrived with `word_cnt` saturated.

## Operation
- States: IDLE, CMD, DATA.
- IDLE:
  - If any enable bit is high, lock the highest-priority one. Priority is IO > OSD > FPGA.
  - Set `ch_sel` and go to CMD.
  - A strobe while all enables are low is ignored.
- CMD:
  - On a strobe: `cmd` <= word, `cmd_valid` = 1, `word_cnt` <= 0, go to DATA.
- DATA:
  - On a strobe: `data` <= word, `data_valid` = 1.
  - `word_cnt` holds the index of this word. It increments after each data word and saturates at all-ones.
  - A data word arriving while `word_cnt` is already all-ones sets `overflow`, and the word is still presented.
- End of transaction, from CMD or DATA:
  - When the locked channel's enable bit goes low: `xfer_end` = 1, `ch_sel` <= 0, go to IDLE.
  - Non-locked enables are ignored while locked, so there is no preemption.
- Strobe and enable-drop in the same cycle: the word is processed first (`cmd_valid` or `data_valid`), and `xfer_end` fires in the same cycle.
- Re-arbitration happens in IDLE on the cycle after `xfer_end`. A channel whose enable is still high is then locked again as a new transaction.
- `gp_in` is a registered mux of the locked channel's response input, updated every cycle. It is 0 when `ch_sel` = 0.
- `overflow` is cleared only by reset.

## Timing
- Reset values:
  - State IDLE.
  - `ch_sel`, `cmd`, `data`, `word_cnt`, `gp_in` all 0.
  - All pulse outputs and `overflow` 0.
- Enable high to `ch_sel` valid: 1 cycle.
- `io_strobe` to `cmd_valid` or `data_valid`: 1 cycle. `cmd`, `data` and `word_cnt` are valid in the same cycle as the pulse.
- `resp_*` to `gp_in`: 1 cycle.
- Back-to-back strobes on consecutive cycles are accepted without loss.
- Reset mid-transaction returns to IDLE immediately.
- Pulse outputs are never high for two consecutive cycles from a single event.

## Configuration
- `HPS_SEQ_WATCHDOG_EN` defined:
  - A cycle counter runs in CMD and DATA and clears on every strobe.
  - When it reaches `TIMEOUT`: `xfer_end` pulses, `ch_sel` <= 0, state goes to IDLE.
  - The locked enable must then go low before that channel can lock again.
- `HPS_SEQ_WATCHDOG_EN` undefined: no counter exists and transactions end only on the enable drop.

## Test plan
- io_en high, strobes 0x0021, 0xAAAA, 0x5555, then io_en low:
  - `ch_sel`=3.
  - `cmd_valid` with `cmd`=0x0021.
  - `data_valid` twice, with `word_cnt` 0 then 1.
  - `xfer_end` one cycle after the drop, `ch_sel`=0.
- fpga_en and osd_en rise in the same cycle:
  - `ch_sel`=2.
  - Lowering fpga_en has no effect.
  - Lowering osd_en gives `xfer_end`, then `ch_sel`=1 on the next arbitration.
- `CNT_W`=2, six data words:
  - `word_cnt` reads 0, 1, 2, 3, 3, 3.
  - `overflow` is set on the fifth data word and stays set.
- `resp_osd`=0x1234 with OSD locked:
  - `gp_in`=0x1234 one cycle later.
  - `gp_in`=0 after `xfer_end`.
- Strobe coincident with the io_en drop: `data_valid` and `xfer_end` pulse in the same cycle.
- Watchdog build, `TIMEOUT`=16, command word then no strobes for 16 cycles:
  - `xfer_end` pulses and `ch_sel`=0.
  - There is no re-lock until io_en toggles low then high.
